// File: rtl/cereal_pkg.sv
// Shared cereal UART types and constants, used by the receiver and the transmitter.
// CEREAL_RX_PARITY_EN selects the 8E1 frame (11 bits) instead of 8N1 (10 bits).
package cereal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int CLKS_PER_BIT_DEF = 5207;

`ifdef CEREAL_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/cereal_fifo.sv
// First-word-fall-through byte FIFO, DEPTH a power of two >= 2.
// Push is dropped when full unless a pop happens in the same cycle; pop is ignored when empty.
module cereal_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             sysclk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_dat  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge sysclk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/cereal_rx.sv
// UART receiver, 8N1 LSB-first (8E1 with CEREAL_RX_PARITY_EN); majority-voted mid-bit samples into a FWFT FIFO.
// Byte visible 1 cycle after the stop decision; rx_ready backpressures, a full FIFO drops new bytes with an overrun pulse.
module cereal_rx
   import cereal_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       serialIn,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun,
   output logic       par_err
);

   localparam int TW  = $clog2(CLKS_PER_BIT);
   localparam int MID = CLKS_PER_BIT / 2;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_M1   = TW'(MID - 1);
   localparam logic [TW-1:0] T_MID  = TW'(MID);
   localparam logic [TW-1:0] T_P1   = TW'(MID + 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   rx_state_t     state_q, state_d;
   logic          sync1_q, sync1_d, sync2_q, sync2_d, ln_prev_q, ln_prev_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          smp0_q, smp0_d, smp1_q, smp1_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          par_err_q, par_err_d;
   logic          par_bit_q, par_bit_d;
   logic          ln, decide, sample, push;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_dat;

   assign ln     = sync2_q;
   assign decide = (tcnt_q == T_P1);
   assign sample = maj3(smp0_q, smp1_q, ln);

   always_comb begin
      sync1_d     = serialIn;
      sync2_d     = sync1_q;
      ln_prev_d   = ln;
      state_d     = state_q;
      tcnt_d      = (tcnt_q == T_LAST) ? '0 : tcnt_q + T_ONE;
      bidx_d      = bidx_q;
      shreg_d     = shreg_q;
      smp0_d      = (tcnt_q == T_M1)  ? ln : smp0_q;
      smp1_d      = (tcnt_q == T_MID) ? ln : smp1_q;
      par_bit_d   = par_bit_q;
      frame_err_d = 1'b0;
      par_err_d   = 1'b0;
      push        = 1'b0;
      case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (ln_prev_q && !ln) state_d = START;
         end
         START: begin
            // A start bit that votes high was a glitch: drop back silently.
            if (decide) begin
               if (!sample) begin
                  state_d = DATA;
                  bidx_d  = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (decide) begin
               shreg_d[bidx_q] = sample;
               if (bidx_q == 3'd7) begin
`ifdef CEREAL_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end
         end
`ifdef CEREAL_RX_PARITY_EN
         PARITY: begin
            if (decide) begin
               par_bit_d = sample;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (decide) begin
               if (!sample) begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end else begin
                  state_d = IDLE;
`ifdef CEREAL_RX_PARITY_EN
                  if ((^shreg_q) ^ par_bit_q) par_err_d = 1'b1;
                  else                        push      = 1'b1;
`else
                  push = 1'b1;
`endif
               end
            end
         end
         BREAK: begin
            tcnt_d = '0;
            if (ln) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      overrun_d = push & fifo_full & ~(rx_ready & ~fifo_empty);
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         ln_prev_q   <= 1'b1;
         tcnt_q      <= '0;
         bidx_q      <= '0;
         shreg_q     <= '0;
         smp0_q      <= 1'b1;
         smp1_q      <= 1'b1;
         par_bit_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         ln_prev_q   <= ln_prev_d;
         tcnt_q      <= tcnt_d;
         bidx_q      <= bidx_d;
         shreg_q     <= shreg_d;
         smp0_q      <= smp0_d;
         smp1_q      <= smp1_d;
         par_bit_q   <= par_bit_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         par_err_q   <= par_err_d;
      end
   end

   cereal_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .sysclk   (sysclk),
      .reset_n  (reset_n),
      .push     (push),
      .push_dat (shreg_q),
      .pop      (rx_ready),
      .rd_dat   (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign rx_valid  = ~fifo_empty;
   assign rx_data   = fifo_empty ? 8'h00 : fifo_dat;
   assign busy      = (state_q != IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef CEREAL_RX_PARITY_EN
   assign par_err   = par_err_q;
`else
   assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cereal_rx.sv
// Randomised bench for cereal_rx: byte-level model (expected-byte queue and error counts) checked against the DUT.
module tb_cereal_rx;

   localparam int C   = 16;
   localparam int MID = C / 2;
   localparam int DEP = 4;
`ifdef CEREAL_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Line drive to rx_valid: 2 sync flops + edge detect, stop-bit start, vote at MID+1, then the push edge.
   localparam int RISE_OFF = 3 + (NB - 1) * C + MID + 2;

   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic       serialIn = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       busy, frame_err, overrun, par_err;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_fe = 0, n_ov = 0, n_pe = 0, n_pop = 0;
   int   rise_cyc = -1;
   logic prev_valid = 1'b0;
   logic saw_busy = 1'b0;
   logic rnd_rdy = 1'b0;
   logic [7:0] exp_q[$];

   cereal_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEP)) dut (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .serialIn  (serialIn),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .par_err   (par_err)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge sysclk) begin
      if (frame_err) n_fe++;
      if (overrun)   n_ov++;
      if (par_err)   n_pe++;
      if (busy)      saw_busy = 1'b1;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) begin
         n_pop++;
         if (exp_q.size() == 0) chk("pop_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
         else                   chk("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
      if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      serialIn = 1'b0;
      repeat (C) tick();
      for (int i = 0; i < 8; i++) begin
         serialIn = d[i];
         repeat (C) tick();
      end
`ifdef CEREAL_RX_PARITY_EN
      serialIn = (^d) ^ par_flip;
      repeat (C) tick();
`else
      if (par_flip) serialIn = 1'b1;
`endif
      serialIn = stop_bit;
      repeat (C) tick();
   endtask

   task automatic drain(input string tag);
      int k;
      rx_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         tick();
         k++;
      end
      repeat (2) tick();
      chk({tag, "_left"}, 32'(exp_q.size()), 0);
      chk({tag, "_valid_low"}, 32'(rx_valid), 0);
      rx_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, fe0, ov0, pe0, pop0, exp_fe, exp_pe;
      logic [7:0] d;
      logic bad, pflip;

      // reset state
      #3;
      chk("rst_valid", 32'(rx_valid), 0);
      chk("rst_data", 32'(rx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_perr", 32'(par_err), 0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (4) tick();

      // 1: single byte, exact latency
      fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
      rise_cyc = -1;
      exp_q.push_back(8'h41);
      c = cyc;
      send_byte(8'h41, 1'b1, 1'b0);
      repeat (2) tick();
      chk("t1_rise_cycle", 32'(rise_cyc), 32'(c + RISE_OFF));
      chk("t1_data", 32'(rx_data), 32'h41);
      chk("t1_errs", 32'(n_fe - fe0 + n_ov - ov0 + n_pe - pe0), 0);
      drain("t1");

      // 2: one-cycle glitch
      fe0 = n_fe;
      saw_busy = 1'b0;
      serialIn = 1'b0;
      tick();
      serialIn = 1'b1;
      repeat (3 * C) tick();
      chk("t2_saw_busy", 32'(saw_busy), 1);
      chk("t2_busy_after", 32'(busy), 0);
      chk("t2_valid", 32'(rx_valid), 0);
      chk("t2_ferr", 32'(n_fe - fe0), 0);

      // 3: bad stop, held-low line, then recovery
      fe0 = n_fe;
      send_byte(8'h55, 1'b0, 1'b0);
      repeat (3 * C) tick();
      chk("t3_ferr", 32'(n_fe - fe0), 1);
      chk("t3_break_busy", 32'(busy), 1);
      chk("t3_valid", 32'(rx_valid), 0);
      serialIn = 1'b1;
      repeat (4) tick();
      chk("t3_idle", 32'(busy), 0);
      exp_q.push_back(8'h0D);
      send_byte(8'h0D, 1'b1, 1'b0);
      repeat (2) tick();
      chk("t3_data", 32'(rx_data), 32'h0D);
      drain("t3");

      // 4: overrun on the fifth byte
      ov0 = n_ov; pop0 = n_pop;
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
      repeat (4) tick();
      chk("t4_overrun", 32'(n_ov - ov0), 1);
      chk("t4_head", 32'(rx_data), 32'h01);
      drain("t4");
      chk("t4_pops", 32'(n_pop - pop0), 4);

      // 5: pop coincides with push into a full FIFO
      ov0 = n_ov; pop0 = n_pop;
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b0);
      c = cyc;
      fork
         send_byte(8'h05, 1'b1, 1'b0);
         begin
            while (cyc < c + RISE_OFF - 1) tick();
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
         end
      join
      repeat (2) tick();
      chk("t5_no_overrun", 32'(n_ov - ov0), 0);
      chk("t5_head", 32'(rx_data), 32'h02);
      drain("t5");
      chk("t5_pops", 32'(n_pop - pop0), 5);

      // 6: reset mid-frame flushes everything
      fe0 = n_fe;
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1, 1'b0);
      repeat (2) tick();
      chk("t6_prefill", 32'(rx_valid), 1);
      c = cyc;
      fork
         send_byte(8'h99, 1'b1, 1'b0);
         begin
            while (cyc < c + 3 + 4 * C + 5) tick();
            chk("t6_busy_before", 32'(busy), 1);
            reset_n = 1'b0;
            #1;
            exp_q.delete();
            chk("t6_rst_outputs", 32'({rx_valid, busy, frame_err, overrun, par_err}), 0);
            chk("t6_rst_data", 32'(rx_data), 0);
         end
      join
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
      chk("t6_after_valid", 32'(rx_valid), 0);
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1, 1'b0);
      repeat (2) tick();
      chk("t6_data", 32'(rx_data), 32'hA5);
      chk("t6_no_ferr", 32'(n_fe - fe0), 0);
      drain("t6");

`ifdef CEREAL_RX_PARITY_EN
      // bad parity drops the byte
      pe0 = n_pe; fe0 = n_fe;
      send_byte(8'h07, 1'b1, 1'b1);
      repeat (4) tick();
      chk("par_err_pulse", 32'(n_pe - pe0), 1);
      chk("par_no_push", 32'(rx_valid), 0);
      chk("par_no_ferr", 32'(n_fe - fe0), 0);
`endif

      // randomised traffic against the byte-level model
      fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
      exp_fe = 0; exp_pe = 0;
      rnd_rdy = 1'b1;
      for (int f = 0; f < 24; f++) begin
         d = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
`ifdef CEREAL_RX_PARITY_EN
         pflip = ($urandom_range(0, 5) == 0);
`else
         pflip = 1'b0;
`endif
         if (bad)        exp_fe++;
         else if (pflip) exp_pe++;
         else            exp_q.push_back(d);
         send_byte(d, !bad, pflip);
         if (bad) begin
            repeat ($urandom_range(C, 3 * C)) tick();
            serialIn = 1'b1;
         end
         repeat ($urandom_range(2, 20)) tick();
      end
      rnd_rdy = 1'b0;
      drain("rnd");
      chk("rnd_ferr", 32'(n_fe - fe0), 32'(exp_fe));
      chk("rnd_perr", 32'(n_pe - pe0), 32'(exp_pe));
      chk("rnd_overrun", 32'(n_ov - ov0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
